// File: rtl/way_decoder.sv
// Registered way decoder: one-hot, round-robin, thermometer and clear modes.
// One output register with a valid/ready handshake on each side.
module way_decoder #(
   parameter int SEL_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_mode,
   input  logic [SEL_W-1:0]      req_sel,
   output logic [(2**SEL_W)-1:0] dec_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      rr_ptr
);

   localparam int OUT_W = 2 ** SEL_W;

   logic             accept;
   logic             is_rr;
   logic [SEL_W-1:0] idx;
   logic [OUT_W-1:0] onehot;
   logic [OUT_W-1:0] therm;
   logic [OUT_W-1:0] nxt;

   // A free slot exists when the register is empty or drains this cycle.
   assign req_ready = !out_valid || out_ready;
   assign accept    = req_valid && req_ready;
   assign is_rr     = (req_mode == 2'b01);
   assign idx       = is_rr ? rr_ptr : req_sel;

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

   always_comb begin
      therm = '0;
      for (int i = 0; i < OUT_W; i++) begin
         therm[i] = (SEL_W'(i) <= req_sel);
      end
   end

   always_comb begin
      nxt = '0;
      unique case (req_mode)
         2'b00: nxt = onehot;
         2'b01: nxt = onehot;
         2'b10: nxt = therm;
         2'b11: nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_out   <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         dec_out   <= nxt;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Pointer wraps naturally since OUT_W is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept && is_rr) begin
         rr_ptr <= rr_ptr + SEL_W'(1);
      end
   end

endmodule
